// File: rtl/multu_hilo_pkg.sv
// Shared ALU definitions: function codes decoded by the ALU, shifter, output MUX
// and the MULTU/HI/LO block, plus the radix-2 shift-add step used by the multiplier.
package multu_hilo_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PROD_W = 2 * WORD_W;
  localparam int unsigned ITER_W = 5;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // One shift-add iteration; the 33-bit sum keeps the carry out of the upper half.
  function automatic logic [PROD_W-1:0] mul_step(input logic [PROD_W-1:0] p,
                                                input logic [WORD_W-1:0] mcand);
    logic [WORD_W:0] sum;
    sum = {1'b0, p[PROD_W-1:WORD_W]} + (p[0] ? {1'b0, mcand} : {(WORD_W+1){1'b0}});
    return {sum, p[WORD_W-1:1]};
  endfunction

endpackage

// File: rtl/multu_hilo_dp.sv
// Multiplier datapath: multiplicand and 64-bit product registers, loaded on accept
// and advanced one shift-add step per RUN cycle.
module multu_hilo_dp
  import multu_hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [PROD_W-1:0] prod_o,
  output logic [PROD_W-1:0] prod_step_o
);

  logic [WORD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] p_q, p_d;

  assign prod_step_o = mul_step(p_q, mcand_q);
  assign prod_o      = p_q;

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    mcand_d = mcand_q;
    p_d     = p_q;
    if (load_i) begin
      mcand_d = a_i;
      p_d     = {{WORD_W{1'b0}}, b_i};
    end else if (step_i) begin
      p_d = prod_step_o;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      mcand_q <= '0;
      p_q     <= '0;
    end else begin
      mcand_q <= mcand_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned 32x32 MULTU with HI/LO result registers feeding the ALU output MUX.
// Accept in IDLE, 32 shift-add cycles in RUN, commit HI/LO with a one-cycle done in DONE.
module multu_hilo
  import multu_hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] dataA,
  input  logic [WORD_W-1:0] dataB,
  input  logic [5:0]        Signal,
  output logic [WORD_W-1:0] HiOut,
  output logic [WORD_W-1:0] LoOut,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [ITER_W-1:0] cnt_q;
  logic [WORD_W-1:0] hi_q, lo_q;
  logic              busy_q, done_q;

  logic              start;
  logic              step;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_step;

  assign start = (state_q == IDLE) && (Signal == FN_MULTU);
  assign step  = (state_q == RUN);

  multu_hilo_dp u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (start),
    .step_i      (step),
    .a_i         (dataA),
    .b_i         (dataB),
    .prod_o      (prod),
    .prod_step_o (prod_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + ITER_W'(1);
          // Commit the product of the final step, so HI/LO update on the RUN->DONE edge.
          if (cnt_q == {ITER_W{1'b1}}) begin
            state_q <= DONE;
            hi_q    <= prod_step[PROD_W-1:WORD_W];
            lo_q    <= prod_step[WORD_W-1:0];
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;

  logic unused_prod;
  assign unused_prod = ^prod;

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential unsigned 32×32 multiplier with its HI/LO result registers. It sits directly upstream of the ALU output multiplexer. The multiplexer consumes `HiOut`/`LoOut` for MFHI/MFLO, and this block produces them. It executes MULTU by radix-2 shift-add over 32 iteration cycles, then commits the 64-bit product to HI/LO.

## Interface
Parameters: none. Widths are fixed by the ISA.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dataA`  in  32  multiplicand (rs).
- `dataB`  in  32  multiplier (rt).
- `Signal`  in  6  function code, shared with the ALU and output MUX.
- `HiOut`  out  32  HI register, upper product word.
- `LoOut`  out  32  LO register, lower product word.
- `busy`  out  1  high while a multiply is in progress (RUN or DONE).
- `done`  out  1  one-cycle pulse when HI/LO has just been committed.

## Operation
- **Start condition.** A MULTU starts when `Signal == 6'b011001` is sampled at a rising edge in IDLE.
  - `dataA` and `dataB` are captured at that edge. They need not stay stable afterwards.
- **Ignored codes.** Any other Signal code (ADD, SUB, AND, OR, SLT, SLL, MFHI, MFLO, …) does not affect this block.
  - MFHI/MFLO only read `HiOut`/`LoOut` through the downstream MUX.
- **States.**
  - IDLE: on MULTU → RUN; otherwise stay.
  - RUN: 32 iterations, counted by a 5-bit counter `cnt`. When the iteration with `cnt == 31` completes → DONE.
  - DONE: commit the product to HI/LO, pulse `done`, then → IDLE unconditionally.
- **Datapath.**
  - Multiplicand register `mcand`, 32 bits.
  - Product register `P`, 64 bits. Load value: `P = {32'b0, dataB}`.
  - Per iteration: `sum[32:0] = {1'b0, P[63:32]} + (P[0] ? {1'b0, mcand} : 33'b0)`, then `P = {sum, P[31:1]}`.
  - The 33-bit sum keeps the carry, so no overflow is possible. After 32 iterations `P = dataA × dataB`, fully unsigned.
- **Commit.** HI ← `P[63:32]` and LO ← `P[31:0]`, written only on the RUN→DONE edge.
  - HI/LO hold the previous result for the whole of RUN. MFHI/MFLO issued during a multiply read the old values.
- **MULTU while busy.** Ignored; no queuing and no restart. The in-flight operation completes with its original operands.
- **MULTU during DONE.** Ignored; it must be reissued once back in IDLE.

## Timing
- **Reset.** `rst_n == 0` at a rising edge forces:
  - state = IDLE, `cnt` = 0, `P` = 0, `mcand` = 0;
  - `HiOut` = 0, `LoOut` = 0, `busy` = 0, `done` = 0.
- **Reset mid-operation.** Abandons the multiply. HI/LO go to 0, not to the partial product.
- **Latency.** MULTU sampled at edge t:
  - edges t+1 … t+32 perform the iterations;
  - at edge t+32 `HiOut`/`LoOut` update and `done` = 1;
  - at edge t+33 `done` = 0 and the state returns to IDLE.
  - Hence 32 cycles from accept to a valid result.
- **busy.** Goes to 1 at edge t and falls at edge t+33.
  - Back-to-back MULTU: the earliest next accept is edge t+33.
- **Output registers.** All outputs are registered; there is no combinational path from inputs to outputs.
- **Simultaneous reset and MULTU.** Reset wins.

## Structure
- **Shared constants.** The function-code constants (ADD, SUB, AND, OR, SLT, SLL, MULTU, MFHI, MFLO) go in the team's shared ALU definitions include, used by this block, the ALU, the shifter and the output MUX.
- **Local constants.** State encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) are local to this module.
- **Sub-modules.** None required. Control (FSM plus counter) and datapath fit in one module of roughly 150 lines.

## Test plan
- Reset low for 2 cycles, then MULTU with dataA = 3, dataB = 5 → `busy` for 33 cycles, `done` pulse exactly 32 cycles after accept, HI = 0x00000000, LO = 0x0000000F.
- dataA = 0xFFFFFFFF, dataB = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 (carry path exercised). dataA = 0x80000000, dataB = 2 → HI = 0x00000001, LO = 0x00000000.
- MULTU 7×9 accepted; 10 cycles later MULTU 2×2 presented → ignored; result HI = 0, LO = 63; the second operation never starts and `done` pulses once.
- After 7×9 commits, MULTU 0×0x12345678 → HI/LO read 0/63 throughout RUN, then 0/0 at commit. Changing dataA/dataB mid-run does not alter the result.
- MULTU 0xFFFFFFFF×2 accepted; `rst_n` low at accept+15 → next cycle HiOut = LoOut = 0, `busy` = 0, `done` never asserted. A fresh MULTU 4×4 afterwards gives LO = 16 with normal latency.
- Non-MULTU codes (ADD, MFHI, MFLO, SLL) held in IDLE for 50 cycles → `busy` stays 0, HI/LO unchanged.
